// File: rtl/riscv_defines_pkg.sv
// Shared RV32 execute-stage definitions used by the iterative divider.
package riscv_defines;

  localparam int XLEN      = 32;
  localparam int DIV_STEPS = 32;
  localparam int DIV_CNT_W = $clog2(DIV_STEPS);

  typedef enum logic [1:0] {
    OP_DIV  = 2'd0,
    OP_DIVU = 2'd1,
    OP_REM  = 2'd2,
    OP_REMU = 2'd3
  } div_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // Divide-related slice of the decoded EX control word.
  typedef struct packed {
    logic    div_sel;
    div_op_t div_op;
  } control_signal_t;

  // Divide-related slice of the hazard unit request.
  typedef struct packed {
    logic div_busy;
  } hazard_req_t;

  function automatic logic op_is_signed(div_op_t o);
    return (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic op_is_rem(div_op_t o);
    return (o == OP_REM) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// state  | meaning
// IDLE   | waiting for a divide op in EX; accepts and stalls in the same cycle
// BUSY   | one restoring step per cycle, 32 steps
// DONE   | result register valid for one cycle, pipeline advances
module div_unit
  import riscv_defines::*;
(
  input  logic            clk,
  input  logic            start,
  input  logic            valid_e,
  input  div_op_t         op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush_e,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0]      INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [DIV_CNT_W-1:0] LAST_STEP = DIV_CNT_W'(DIV_STEPS - 1);

  div_state_t           state_q, state_d;
  logic [DIV_CNT_W-1:0] count_q, count_d;
  div_op_t              op_q, op_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic [XLEN:0]        rem_q, rem_d;
  logic [XLEN-1:0]      quo_q, quo_d;
  logic [XLEN-1:0]      dvs_q, dvs_d;
  logic [XLEN-1:0]      result_q, result_d;

  logic                 accept;
  logic                 acc_sa, acc_sb;
  logic [XLEN-1:0]      mag_a, mag_b;
  logic                 ovf;
  logic [XLEN+1:0]      diff;
  logic                 step_ge;
  logic [XLEN:0]        rem_step;
  logic [XLEN-1:0]      quo_step, quo_fix, rem_fix;

  // Operand decode at accept; magnitudes stay raw for the unsigned ops.
  assign accept = (state_q == S_IDLE) && valid_e && !flush_e;
  assign acc_sa = op_is_signed(op) & in_a[XLEN-1];
  assign acc_sb = op_is_signed(op) & in_b[XLEN-1];
  assign mag_a  = acc_sa ? -in_a : in_a;
  assign mag_b  = acc_sb ? -in_b : in_b;
  assign ovf    = op_is_signed(op) && (in_a == INT_MIN) && (in_b == '1);

  // Stall request; gated by reset so a held valid_e cannot stall the pipe in reset.
  assign busy = start && !flush_e &&
                (((state_q == S_IDLE) && valid_e) || (state_q == S_BUSY));
  assign result_valid = (state_q == S_DONE);
  assign result       = result_q;

  // One restoring step: the dividend shifts out of quo_q into the partial remainder.
  always_comb begin
    diff     = {rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};
    step_ge  = ~diff[XLEN+1];
    rem_step = step_ge ? diff[XLEN:0] : {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    quo_step = {quo_q[XLEN-2:0], step_ge};
    quo_fix  = (sign_a_q ^ sign_b_q) ? -quo_step : quo_step;
    rem_fix  = sign_a_q ? -rem_step[XLEN-1:0] : rem_step[XLEN-1:0];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d     = op;
          sign_a_d = acc_sa;
          sign_b_d = acc_sb;
          rem_d    = '0;
          quo_d    = mag_a;
          dvs_d    = mag_b;
          count_d  = '0;
          if (in_b == '0) begin
            result_d = op_is_rem(op) ? in_a : '1;
            state_d  = S_DONE;
          end else if (ovf) begin
            result_d = op_is_rem(op) ? '0 : INT_MIN;
            state_d  = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (flush_e) begin
          state_d = S_IDLE;
        end else begin
          rem_d   = rem_step;
          quo_d   = quo_step;
          count_d = count_q + 1'b1;
          if (count_q == LAST_STEP) begin
            state_d  = S_DONE;
            result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      op_q     <= OP_DIV;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, latency, stall length, flush and reset.
module tb_div_unit;
  import riscv_defines::*;

  logic        clk = 1'b0;
  logic        start = 1'b0;
  logic        valid_e = 1'b0;
  logic        flush_e = 1'b0;
  div_op_t     op = OP_DIVU;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  div_unit dut (
    .clk          (clk),
    .start        (start),
    .valid_e      (valid_e),
    .op           (op),
    .in_a         (in_a),
    .in_b         (in_b),
    .flush_e      (flush_e),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op at the current cycle and follow it to result_valid.
  task automatic do_div(input string tag, input div_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input bit hold);
    int busy_cnt;
    int lat;
    busy_cnt = 0;
    lat      = -1;
    op = o; in_a = a; in_b = b; valid_e = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (result_valid) begin
        lat = c;
        break;
      end
      tick();
    end
    chk({tag, " result"}, result, exp_res);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat));
    if (!hold) valid_e = 1'b0;
    if (lat >= 0) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in reset busy", 32'(busy), 32'd0);
    chk("in reset result_valid", 32'(result_valid), 32'd0);
    chk("in reset result", result, 32'd0);
    start = 1'b1;
    tick();
    @(negedge clk);
    chk("idle busy", 32'(busy), 32'd0);
    chk("idle result", result, 32'd0);

    // A divide op being flushed in IDLE must not stall or start.
    tick();
    valid_e = 1'b1; flush_e = 1'b1; op = OP_DIVU; in_a = 32'd10; in_b = 32'd2;
    @(negedge clk);
    chk("flushed accept busy", 32'(busy), 32'd0);
    tick();
    valid_e = 1'b0; flush_e = 1'b0;
    @(negedge clk);
    chk("flushed accept no result_valid", 32'(result_valid), 32'd0);
    chk("flushed accept no busy", 32'(busy), 32'd0);
    tick();

    do_div("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    do_div("REMU 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    do_div("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
    do_div("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
    do_div("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
    do_div("REM 7/-2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 1'b0);
    do_div("DIVU 1234/0", OP_DIVU, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    do_div("REMU 1234/0", OP_REMU, 32'h1234, 32'd0, 32'h1234, 1, 1'b0);
    do_div("DIV -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    do_div("REM -5/0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, 1'b0);
    do_div("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    do_div("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    do_div("DIVU 80000000/FFFFFFFF", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
    do_div("REMU 80000000/FFFFFFFF", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
    do_div("DIVU FFFFFFFF/1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 1'b0);
    do_div("DIV -100/-7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33, 1'b0);

    // Flush mid-operation at T+10, then a fresh op at T+12.
    op = OP_DIVU; in_a = 32'd1000; in_b = 32'd3; valid_e = 1'b1;
    @(negedge clk);
    chk("flush test accept busy", 32'(busy), 32'd1);
    repeat (10) tick();
    flush_e = 1'b1;
    @(negedge clk);
    chk("flush cycle busy", 32'(busy), 32'd0);
    chk("flush cycle result_valid", 32'(result_valid), 32'd0);
    tick();
    flush_e = 1'b0; valid_e = 1'b0;
    @(negedge clk);
    chk("after flush busy", 32'(busy), 32'd0);
    chk("after flush result_valid", 32'(result_valid), 32'd0);
    chk("after flush result held", result, 32'd14);
    tick();
    do_div("DIVU 9/3 after flush", OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 1'b0);

    // Asynchronous reset mid-operation at T+5.
    op = OP_DIVU; in_a = 32'd100; in_b = 32'd7; valid_e = 1'b1;
    repeat (5) tick();
    start = 1'b0;
    #1;
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset result", result, 32'd0);
    chk("async reset result_valid", 32'(result_valid), 32'd0);
    valid_e = 1'b0;
    @(negedge clk);
    start = 1'b1;
    tick();
    @(negedge clk);
    chk("post reset busy", 32'(busy), 32'd0);
    tick();

    // Back-to-back with valid_e held through DONE.
    do_div("b2b DIVU 20/4", OP_DIVU, 32'd20, 32'd4, 32'd5, 33, 1'b1);
    do_div("b2b DIVU 21/4", OP_DIVU, 32'd21, 32'd4, 32'd5, 33, 1'b0);
    @(negedge clk);
    chk("end idle result_valid", 32'(result_valid), 32'd0);
    chk("end idle result held", result, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
